// File: rtl/vec_pair_scatter_if.sv
// Result-pair in / lane-bundle out handshake bundle for vec_pair_scatter.
// Ports: in_valid/in_ready, d_a, d_b, s, flush (producer side);
//        out_valid/out_ready, q0..q3, out_mask (consumer side).
interface vec_pair_scatter_if #(
    parameter int WIDTH = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d_a;
    logic [WIDTH-1:0] d_b;
    logic [1:0]       s;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] q1;
    logic [WIDTH-1:0] q2;
    logic [WIDTH-1:0] q3;
    logic [3:0]       out_mask;

    // Environment side: drives result pairs and downstream ready.
    modport master (
        output in_valid, d_a, d_b, s, flush, out_ready,
        input  in_ready, out_valid, q0, q1, q2, q3, out_mask
    );

    // Block side.
    modport slave (
        input  in_valid, d_a, d_b, s, flush, out_ready,
        output in_ready, out_valid, q0, q1, q2, q3, out_mask
    );
endinterface

// File: rtl/vec_pair_scatter.sv
// Scatters (a, b) result pairs into a 4-lane bundle and emits it downstream.
// Ports: clk, rst (sync, active-high), bus (vec_pair_scatter_if.slave),
//        ovw_err (sticky: a lane was written twice within one bundle).
// Option: PAIR_SCATTER_BYPASS_EN lets a new pair be accepted on the emit cycle.
module vec_pair_scatter #(
    parameter int WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    vec_pair_scatter_if.slave     bus,
    output logic                  ovw_err
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0][WIDTH-1:0]   lane_q, lane_d;
    logic [3:0]              mask_q, mask_d;
    logic                    ovw_q, ovw_d;

    logic       hold;
    logic       in_ready;
    logic       accept;
    logic       emit;
    logic [3:0] tgt;
    logic       qualify;

    always_comb begin
        hold = (state_q == HOLD);
`ifdef PAIR_SCATTER_BYPASS_EN
        in_ready = !hold || bus.out_ready;
`else
        in_ready = !hold;
`endif
        accept = bus.in_valid && in_ready;
        emit   = hold && bus.out_ready;

        tgt = 4'b0000;
        unique case (bus.s)
            2'b00, 2'b01: tgt = 4'b0011;
            2'b10:        tgt = 4'b1100;
            2'b11:        tgt = 4'b0101;
            default:      tgt = 4'b0000;
        endcase

        // An emit clears the bundle first, so a same-cycle accept
        // lands in an empty bundle.
        lane_d = emit ? '0 : lane_q;
        mask_d = emit ? 4'b0000 : mask_q;
        ovw_d  = ovw_q;

        if (accept) begin
            unique case (bus.s)
                2'b00, 2'b01: begin
                    lane_d[0] = bus.d_a;
                    lane_d[1] = bus.d_b;
                end
                2'b10: begin
                    lane_d[2] = bus.d_a;
                    lane_d[3] = bus.d_b;
                end
                2'b11: begin
                    lane_d[2] = bus.d_a;
                    lane_d[0] = bus.d_b;
                end
                default: ;
            endcase
            if ((mask_d & tgt) != 4'b0000) begin
                ovw_d = 1'b1;
            end
            mask_d = mask_d | tgt;
        end

        // flush only matters when a collection edge is taken; in HOLD
        // without emit the state is held below regardless.
        qualify = (mask_d == 4'b1111) ||
                  (bus.flush && (mask_d != 4'b0000));

        if (hold && !emit) begin
            state_d = HOLD;
        end else if (qualify) begin
            state_d = HOLD;
        end else begin
            state_d = COLLECT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            lane_q  <= '0;
            mask_q  <= 4'b0000;
            ovw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            mask_q  <= mask_d;
            ovw_q   <= ovw_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = hold;
    assign bus.q0        = lane_q[0];
    assign bus.q1        = lane_q[1];
    assign bus.q2        = lane_q[2];
    assign bus.q3        = lane_q[3];
    assign bus.out_mask  = mask_q;
    assign ovw_err       = ovw_q;

endmodule

// File: doc/vec_pair_scatter.md
Name: vec_pair_scatter

Overview:
- Write-back counterpart of the operand-pair select path in the vector processor.
- Accepts result pairs (a, b) with a 2-bit slot code and scatters them into a 4-slot lane bundle.
- Emits the completed 4×WIDTH bundle downstream with a valid/ready handshake.
- Sits between the vector ALU result stage and the vector register-file write port.

Parameters:
- WIDTH, 24, bit width of one lane element.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  result pair present.
- in_ready  output  1  block accepts a pair this cycle.
- d_a  input  WIDTH  first result element.
- d_b  input  WIDTH  second result element.
- s  input  2  slot code.
- flush  input  1  force emission of a partial bundle.
- out_valid  output  1  bundle valid.
- out_ready  input  1  downstream accepts the bundle.
- q0, q1, q2, q3  output  WIDTH each  bundle lanes.
- out_mask  output  4  lanes written in the current bundle (bit i = qi).
- ovw_err  output  1  sticky flag: a slot was written twice within one bundle.

Behaviour:
- Interface: single clock clk. Reset rst is synchronous and active-high.
- Reset: state=COLLECT; q0..q3=0; out_mask=0; out_valid=0; ovw_err=0. in_ready=1 in the first cycle after reset.
- Accept event: in_valid && in_ready at a rising edge.
- Slot mapping on an accept:
  - s=00 or 01: q0←d_a, q1←d_b.
  - s=10: q2←d_a, q3←d_b.
  - s=11: q2←d_a, q0←d_b.
  - The corresponding out_mask bits are set.
- Overwrite: an accept that targets a slot whose out_mask bit is already 1 overwrites that slot's data and sets ovw_err. ovw_err clears only on rst.
- States:
  - COLLECT: in_ready=1, out_valid=0.
    - Go to HOLD when, after this edge's update, out_mask==4'b1111.
    - Also go to HOLD when flush=1 and the post-update out_mask!=0. A beat accepted in the same cycle as flush is included in the bundle.
    - flush with out_mask==0 and no accept: ignored, stay in COLLECT.
  - HOLD: out_valid=1 and in_ready=0 (registered, so the first HOLD cycle is the cycle after the completing accept). q0..q3 and out_mask are stable while out_valid=1 && out_ready=0.
    - out_valid && out_ready at an edge: clear q0..q3 to 0 and out_mask to 0, return to COLLECT.
    - flush is ignored in HOLD.
- Latency: the accept that fills the last slot at edge N gives out_valid=1 in cycle N+1. Minimum bundle period with full-rate producer and out_ready tied high: 2 accepts + 1 HOLD cycle = 3 cycles.
- Unwritten lanes of a flushed bundle read 0.
- rst mid-operation: any partial bundle is discarded and any pending HOLD bundle is dropped without handshake.
- No arithmetic. All data paths are pure WIDTH-bit register transfers.

Optional Feature:
- Macro: PAIR_SCATTER_BYPASS_EN.
- Defined:
  - In HOLD, in_ready = out_ready.
  - An accept in the same cycle as the emit handshake writes into the freshly cleared bundle: non-target lanes=0, out_mask = only the target bits.
  - Next state is HOLD again if that single beat plus flush qualifies, otherwise COLLECT.
  - Minimum bundle period becomes 2 cycles.
- Undefined: in HOLD, in_ready=0 unconditionally, as described above.

Test Plan:
- Full bundle: rst, then accept (s=00, a=0x000001, b=0x000002) and (s=10, a=0x000003, b=0x000004), out_ready=1 → out_valid=1 one cycle after the 2nd accept; q0..q3 = 1,2,3,4; out_mask=1111; then cleared to 0 and back to COLLECT.
- Mixed code: accept s=11 (a=0xAAAAAA, b=0xBBBBBB), then s=01 (a=0x111111, b=0x222222) → q0=0x111111, q1=0x222222, q2=0xAAAAAA, q3=0 and not full (out_valid=0); ovw_err=1 because q0 was rewritten.
- Backpressure: complete a bundle with out_ready=0 for 5 cycles → out_valid held, q*/out_mask stable, in_ready=0; raise out_ready → single emit, then in_ready=1 the next cycle.
- Flush: accept s=10 (a=5, b=6) with flush=1 in the same cycle → next cycle out_valid=1, q=0,0,5,6, out_mask=1100. flush alone with an empty bundle → no out_valid.
- Reset mid-bundle: accept s=00, assert rst for 1 cycle → out_mask=0, q*=0, ovw_err=0, in_ready=1.
- Bypass (macro on): hold a bundle in HOLD, out_ready=1 plus accept s=00 (a=7, b=8) in the same cycle → emit, then q=7,8,0,0, out_mask=0011, state COLLECT.
